// File: rtl/mem_slave.sv
// mem_slave: byte-addressed memory responder for the burst read/write bus.
// Read bursts arrive on AR/R and write bursts on AW/W/B. Two independent
// channel FSMs serve them from one internal byte array.
//
// Parameters
//   MEM_DEPTH  number of implemented bytes (1..256); higher addresses are out of range
// Ports
//   clk, rst                clock (rising edge), asynchronous active-high reset
//   ARVALID, AR[15:0]       read request: [15:8] start, [7:4] length-1, [3:0] ID
//   ARREADY                 one-cycle accept pulse
//   RVALID, RDATA[8:0]      read beat: [8:1] byte, [0] out-of-range flag
//   RLAST, RREADY           final beat marker, master accept
//   AWVALID, AW[11:0]       write request: [11:4] start, [3:0] ID
//   AWREADY                 one-cycle accept pulse
//   WVALID, WDATA, WLAST    write beat, byte, final-beat marker
//   WREADY                  slave accepts write beats
//   BVALID, BRESP[4:0]      write response: [4:1] ID, [0] error; BREADY accepts it
//   RIDLE, WIDLE            channel FSM in idle (registered)
//   RIDLE_prev, WIDLE_prev  RIDLE/WIDLE delayed by one cycle
// Build option
//   SLAVE_MEM_CLEAR_EN      when defined, rst clears every byte to 8'h00;
//                           otherwise memory holds mem[i] = i from power-up
//                           and rst leaves it untouched.
`timescale 1ns/1ps
module mem_slave #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ARVALID,
    input  logic [15:0] AR,
    output logic        ARREADY,
    output logic        RVALID,
    output logic [8:0]  RDATA,
    output logic        RLAST,
    input  logic        RREADY,
    input  logic        AWVALID,
    input  logic [11:0] AW,
    output logic        AWREADY,
    input  logic        WVALID,
    input  logic [7:0]  WDATA,
    input  logic        WLAST,
    output logic        WREADY,
    output logic        BVALID,
    output logic [4:0]  BRESP,
    input  logic        BREADY,
    output logic        RIDLE,
    output logic        WIDLE,
    output logic        RIDLE_prev,
    output logic        WIDLE_prev
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    // Each byte is stored XORed with its own address, so the all-zero
    // power-up contents read back as mem[i] = i without an init process.
    // All 256 entries exist so any 8-bit address indexes cleanly; entries at
    // or above MEM_DEPTH are never read or written.
    logic [7:0] mem_x [256];

    function automatic logic in_range(input logic [7:0] a);
        return {24'd0, a} < 32'(MEM_DEPTH);
    endfunction

    // ---------------- read channel ----------------
    r_state_t   r_state, r_next;
    logic [7:0] r_start;
    logic [3:0] r_len;
    logic [3:0] r_beat;
    logic [3:0] r_load_idx;
    logic [7:0] r_load_addr;
    logic [8:0] r_load_data;

    // The read ID has no return path on this bus.
    logic unused_rid;
    assign unused_rid = ^AR[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ARVALID) r_next = R_ADDR;
            R_ADDR:  r_next = R_DATA;
            R_DATA:  if (RREADY && (r_beat == r_len)) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        ARREADY = (r_state == R_ADDR);
        RVALID  = (r_state == R_DATA);
    end

    // Beat 0 is loaded in R_ADDR; later beats are loaded on each handshake.
    always_comb begin
        r_load_idx  = (r_state == R_DATA) ? r_beat + 4'd1 : 4'd0;
        r_load_addr = r_start + {4'd0, r_load_idx};
        r_load_data = in_range(r_load_addr) ? {mem_x[r_load_addr] ^ r_load_addr, 1'b0}
                                            : 9'h001;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            RDATA   <= '0;
            RLAST   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (ARVALID) begin
                    r_start <= AR[15:8];
                    r_len   <= AR[7:4];
                end
                R_ADDR: begin
                    r_beat <= '0;
                    RDATA  <= r_load_data;
                    RLAST  <= (r_len == 4'd0);
                end
                R_DATA: if (RREADY) begin
                    if (r_beat == r_len) begin
                        RLAST <= 1'b0;
                    end else begin
                        r_beat <= r_load_idx;
                        RDATA  <= r_load_data;
                        RLAST  <= (r_load_idx == r_len);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- write channel ----------------
    w_state_t   w_state, w_next;
    logic [7:0] w_start;
    logic [3:0] w_id;
    logic [4:0] w_cnt;
    logic       w_err;
    logic       w_hs;
    logic [7:0] w_addr;
    logic       w_drop;
    logic       mem_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (AWVALID) w_next = W_ADDR;
            W_ADDR:  w_next = W_DATA;
            W_DATA:  if (WVALID && WLAST) w_next = W_RESP;
            W_RESP:  if (BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        AWREADY = (w_state == W_ADDR);
        WREADY  = (w_state == W_DATA);
        BVALID  = (w_state == W_RESP);
    end

    // The counter saturates at 16, so every beat past the 16th stays dropped.
    always_comb begin
        w_hs   = (w_state == W_DATA) && WVALID;
        w_addr = w_start + {4'd0, w_cnt[3:0]};
        w_drop = w_cnt[4] || !in_range(w_addr);
        mem_we = w_hs && !w_drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_start <= '0;
            w_id    <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            BRESP   <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (AWVALID) begin
                    w_start <= AW[11:4];
                    w_id    <= AW[3:0];
                end
                W_ADDR: begin
                    w_cnt <= '0;
                    w_err <= 1'b0;
                end
                W_DATA: if (w_hs) begin
                    if (!w_cnt[4]) w_cnt <= w_cnt + 5'd1;
                    if (w_drop)    w_err <= 1'b1;
                    if (WLAST)     BRESP <= {w_id, w_err | w_drop};
                end
                default: ;
            endcase
        end
    end

`ifdef SLAVE_MEM_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_x[i] <= 8'(i);
        end else if (mem_we) begin
            mem_x[w_addr] <= WDATA ^ w_addr;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) mem_x[w_addr] <= WDATA ^ w_addr;
    end
`endif

    // ---------------- idle flags ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RIDLE      <= 1'b1;
            WIDLE      <= 1'b1;
            RIDLE_prev <= 1'b1;
            WIDLE_prev <= 1'b1;
        end else begin
            RIDLE      <= (r_next == R_IDLE);
            WIDLE      <= (w_next == W_IDLE);
            RIDLE_prev <= RIDLE;
            WIDLE_prev <= WIDLE;
        end
    end

endmodule
